// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, FSM state type and keep-mask helper for the
// FIFO read-side byte-to-word packer (fifo_rd_packer).
package fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  // IDLE: no bytes accumulated; ACCUM: 1..3 bytes accumulated.
  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Contiguous lane mask for n valid bytes (n = 0..4).
  function automatic logic [LANES-1:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd0:    keep_mask = 4'b0000;
      3'd1:    keep_mask = 4'b0001;
      3'd2:    keep_mask = 4'b0011;
      3'd3:    keep_mask = 4'b0111;
      default: keep_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_packer_timer.sv
// fifo_rd_packer_timer: idle-cycle counter that requests an auto-flush of a
// partial word. Only instantiated when FIFO_RD_PACKER_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   count_en   - one idle (no-pop) cycle spent in ACCUM
//   clear      - restart the count (pop, or packer not accumulating)
//   expire     - this idle cycle is the TIMEOUT_CYCLES-th in a row
module fifo_rd_packer_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // The count saturates at LAST so expire keeps firing while the output
  // register is stalled; the packer holds the flush as pending meanwhile.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign expire = count_en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from a FIFO read port and packs them, first byte
// in [7:0], into 32-bit words on a valid/ready output with a byte keep mask.
// Partial words leave on flush (or, with FIFO_RD_PACKER_TIMEOUT_EN defined,
// after TIMEOUT_CYCLES idle cycles in ACCUM).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   fifo_empty, fifo_rd_data - FIFO status and head byte
//   fifo_rd_en               - pop request (combinational)
//   flush                    - force emission of a partial word
//   m_valid, m_ready         - output handshake
//   m_data, m_keep           - packed word and contiguous lane mask
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic [3:0]        m_keep
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [LANES-1:0]    keep_q, keep_d;
  logic                valid_q, valid_d;
  logic                pend_q, pend_d;

  logic                pop;
  logic                out_free;
  logic                tmo_flush;
  logic                flush_req;
  logic [2:0]          fill;
  logic                emit_full;
  logic                emit_part;

  // Lane 3 may only be filled when the output register can take the word.
  assign fifo_rd_en = !fifo_empty && ((lane_q != 2'd3) || !valid_q || m_ready);
  assign pop        = fifo_rd_en;
  assign out_free   = !valid_q || m_ready;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  fifo_rd_packer_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .count_en((state_q == ACCUM) && !pop),
    .clear   (pop || (state_q == IDLE)),
    .expire  (tmo_flush)
  );
`else
  assign tmo_flush = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    pend_d  = pend_q;

    // Byte count including a same-cycle pop (0..4).
    fill      = {1'b0, lane_q} + {2'b00, pop};
    flush_req = flush || pend_q || tmo_flush;
    emit_full = pop && (lane_q == 2'd3);
    emit_part = !emit_full && flush_req && (fill != 3'd0) && out_free;

    if (pop) begin
      acc_d[{lane_q, 3'b000} +: BYTE_W] = fifo_rd_data;
    end

    if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE, ACCUM: begin
        if (emit_full || emit_part) begin
          // Accumulator lanes above the fill are always zero, so the
          // partial word goes out with its unused lanes cleared.
          data_d  = acc_d;
          keep_d  = keep_mask(fill);
          valid_d = 1'b1;
          acc_d   = '0;
          lane_d  = 2'd0;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          lane_d  = lane_q + {1'b0, pop};
          // Flush with bytes held but output stalled stays pending;
          // a flush with nothing held is dropped.
          pend_d  = flush_req && (fill != 3'd0);
          state_d = (fill != 3'd0) ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: directed vector table, hand-written corner
// sequences and randomized traffic against a byte-queue reference model.
// Covers the FIFO_RD_PACKER_TIMEOUT_EN build when that macro is defined.
module tb_fifo_rd_packer;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  always #5 clk = ~clk;

  fifo_rd_packer #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_keep      (m_keep)
  );

  int total = 0;
  int bad   = 0;

  // Source FIFO contents, and words seen leaving the DUT ({keep, data}).
  logic [7:0]  fq[$];
  logic [35:0] dut_got[$];
  logic        gate_empty;

  // Reference model: bytes held so far, output slot, pending flush, idle count.
  logic [7:0]  mq[$];
  logic        mv;
  logic [31:0] md;
  logic [3:0]  mk;
  logic        mpend;
  int unsigned mtc;
  logic        last_pop;

  typedef struct {
    logic        e;
    logic [7:0]  d;
    logic        f;
    logic        r;
    logic        x_rd;
    logic        x_v;
    logic [31:0] x_data;
    logic [3:0]  x_keep;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mv = 1'b0; md = '0; mk = '0; mpend = 1'b0; mtc = 0; last_pop = 1'b0;
  endtask

  // One clock edge of the reference model, computed from byte-list rules.
  task automatic model_edge();
    int   n0;
    logic freeb;
    logic fl;
    logic fire;
    n0 = mq.size();
    last_pop = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    last_pop = !fifo_empty && (n0 < 3 || !mv || m_ready);
    freeb    = !mv || m_ready;
    fire     = 1'b0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    if (n0 > 0 && !last_pop) begin
      if (mtc < TMO) mtc++;
    end else begin
      mtc = 0;
    end
    fire = (mtc == TMO);
`endif
    if (last_pop) mq.push_back(fifo_rd_data);
    fl = flush || mpend || fire;
    if (mq.size() == 4 || (fl && mq.size() > 0 && freeb)) begin
      md = '0;
      foreach (mq[i]) md[8*i +: 8] = mq[i];
      mk    = 4'((1 << mq.size()) - 1);
      mv    = 1'b1;
      mpend = 1'b0;
      mq.delete();
    end else begin
      if (mv && m_ready) mv = 1'b0;
      mpend = fl && (mq.size() > 0);
    end
  endtask

  // Inputs are already driven (we are at a negedge); check, clock, advance.
  task automatic step();
    logic exp_rd;
    #1;
    exp_rd = !fifo_empty && (mq.size() < 3 || !mv || m_ready);
    chk("rd_en", {35'd0, fifo_rd_en}, {35'd0, exp_rd});
    chk("m_valid", {35'd0, m_valid}, {35'd0, mv});
    if (mv) chk("word", {m_keep, m_data}, {mk, md});
    if (m_valid && m_ready && !rst) dut_got.push_back({m_keep, m_data});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic qdrive(input logic f, input logic r);
    fifo_empty   = gate_empty || (fq.size() == 0);
    fifo_rd_data = (fq.size() > 0) ? fq[0] : 8'h00;
    flush        = f;
    m_ready      = r;
    step();
    if (last_pop) void'(fq.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_empty = 1'b1; fifo_rd_data = '0; flush = 1'b0; m_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {35'd0, m_valid}, 36'd0);
    chk("rst_word", {m_keep, m_data}, 36'd0);
    chk("rst_rd_en", {35'd0, fifo_rd_en}, 36'd0);
    step();
    step();
    rst = 1'b0;
    fq.delete();
  endtask

  initial begin
    gate_empty = 1'b0;
    tv[0]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[1]  = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[2]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[3]  = '{1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'hF};
    tv[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0};
    tv[6]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[7]  = '{1'b0, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0};
    tv[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0};
    tv[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 4'h3};
    tv[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0};
    tv[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0};

    do_reset();

    // Full word, partial flush, flush in IDLE.
    for (int i = 0; i < 12; i++) begin
      fifo_empty = tv[i].e; fifo_rd_data = tv[i].d; flush = tv[i].f; m_ready = tv[i].r;
      #1;
      chk($sformatf("vec%0d_rd", i), {35'd0, fifo_rd_en}, {35'd0, tv[i].x_rd});
      chk($sformatf("vec%0d_valid", i), {35'd0, m_valid}, {35'd0, tv[i].x_v});
      if (tv[i].x_v) chk($sformatf("vec%0d_word", i), {m_keep, m_data}, {tv[i].x_keep, tv[i].x_data});
      step();
    end

    // Stalled output: first word held, lane 3 full blocks popping, then two
    // words back-to-back once m_ready rises.
    for (int b = 1; b <= 8; b++) fq.push_back(8'(b));
    for (int i = 0; i < 10; i++) qdrive(1'b0, 1'b0);
    chk("stall_word", {m_keep, m_data}, {4'hF, 32'h04030201});
    chk("stall_valid", {35'd0, m_valid}, 36'd1);
    chk("stall_rd_en", {35'd0, fifo_rd_en}, 36'd0);
    chk("stall_left", 36'(fq.size()), 36'd1);
    qdrive(1'b0, 1'b1);
    fifo_empty = 1'b1; flush = 1'b0; m_ready = 1'b1;
    #1;
    chk("b2b_valid", {35'd0, m_valid}, 36'd1);
    chk("b2b_word", {m_keep, m_data}, {4'hF, 32'h08070605});
    qdrive(1'b0, 1'b1);
    qdrive(1'b0, 1'b1);

    // Flush arriving while the output is stalled must stay pending.
    dut_got.delete();
    for (int b = 1; b <= 6; b++) fq.push_back(8'(b));
    for (int i = 0; i < 8; i++) qdrive(1'b0, 1'b0);
    qdrive(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) qdrive(1'b0, 1'b1);
    chk("pend_count", 36'(dut_got.size()), 36'd2);
    if (dut_got.size() == 2) begin
      chk("pend_w0", dut_got[0], {4'hF, 32'h04030201});
      chk("pend_w1", dut_got[1], {4'h3, 32'h00000605});
    end

    // Reset mid-word with a stalled output word: nothing stale emitted.
    for (int b = 0; b < 6; b++) fq.push_back(8'hE1 + 8'(b));
    for (int i = 0; i < 8; i++) qdrive(1'b0, 1'b0);
    do_reset();
    dut_got.delete();
    fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
    for (int i = 0; i < 8; i++) qdrive(1'b0, 1'b1);
    chk("rst_count", 36'(dut_got.size()), 36'd1);
    if (dut_got.size() == 1) chk("rst_word_c", dut_got[0], {4'hF, 32'hC4C3C2C1});

    // Single byte then idle FIFO.
    fq.push_back(8'h5A);
    qdrive(1'b0, 1'b1);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) qdrive(1'b0, 1'b1);
    fifo_empty = 1'b1; flush = 1'b0; m_ready = 1'b1;
    #1;
    chk("tmo_valid", {35'd0, m_valid}, 36'd1);
    chk("tmo_word", {m_keep, m_data}, {4'h1, 32'h0000005A});
`else
    for (int i = 0; i < 30; i++) qdrive(1'b0, 1'b1);
    chk("notmo_valid", {35'd0, m_valid}, 36'd0);
    qdrive(1'b1, 1'b1);
    fifo_empty = 1'b1; flush = 1'b0; m_ready = 1'b1;
    #1;
    chk("flush_word", {m_keep, m_data}, {4'h1, 32'h0000005A});
`endif
    qdrive(1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 45 && fq.size() < 20) fq.push_back(8'($urandom));
      gate_empty = ($urandom_range(0, 3) == 0);
      qdrive($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    gate_empty = 1'b0;
    for (int i = 0; i < 40; i++) qdrive(1'b1, 1'b1);
    chk("drained", 36'(fq.size()), 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: idle cycles before auto-flush of a partial word (range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock, the FIFO read-side clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 The block SHALL have port fifo_rd_data, input, 8 bits: FIFO head byte, asynchronously read and valid whenever fifo_empty=0.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: pop request; the FIFO pops on a clk edge where fifo_rd_en=1 and fifo_empty=0.
REQ-008 The block SHALL have port flush, input, 1 bit: force emission of a partial word.
REQ-009 The block SHALL have port m_valid, output, 1 bit: output word valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-011 The block SHALL have port m_data, output, 32 bits: packed word, first byte in [7:0].
REQ-012 The block SHALL have port m_keep, output, 4 bits: byte-lane valid mask, contiguous from bit 0.

Function
REQ-013 The block SHALL define a pop as fifo_rd_en=1 and fifo_empty=0 at a clk edge; the byte captured SHALL be fifo_rd_data in that same cycle.
REQ-014 The block SHALL drive fifo_rd_en = !fifo_empty and (lane_cnt<3, or m_valid=0, or m_ready=1), combinationally from registers and inputs.
REQ-015 The block SHALL write popped bytes into accumulator lane lane_cnt (0..3) and then increment lane_cnt modulo 4.
REQ-016 On the pop that fills lane 3, the block SHALL load the 4 bytes into the output register at that same edge with m_keep=4'b1111, assert m_valid from the next cycle, and return lane_cnt to 0.
REQ-017 The block SHALL hold m_data, m_keep and m_valid stable while m_valid=1 and m_ready=0.
REQ-018 A transfer SHALL occur at an edge where m_valid=1 and m_ready=1; m_valid SHALL deassert afterwards unless a new word loads at the same edge, giving back-to-back words with no bubble.
REQ-019 The FSM SHALL have states IDLE (lane_cnt=0) and ACCUM (lane_cnt 1..3), with transitions: IDLE->ACCUM on a pop; ACCUM->IDLE on a 4th byte or on a flush; otherwise hold.
REQ-020 When flush=1 in ACCUM and the output register is free or being accepted, the block SHALL emit the partial word, including any byte popped in the same cycle, with m_keep = (1<<count)-1 and unused lanes zero.
REQ-021 A flush SHALL be ignored in IDLE with no same-cycle pop, and SHALL remain pending, not lost, while the output register is stalled.
REQ-022 A flush coinciding with the 4th-byte pop SHALL produce a single full word with m_keep=4'b1111.
REQ-023 The block SHALL pop no more than one byte per cycle and SHALL never pop while fifo_empty=1.

Reset
REQ-024 Asserting rst SHALL immediately force m_valid=0, m_data=0, m_keep=0, lane_cnt=0, state=IDLE, pending flush=0 and timeout counter=0; fifo_rd_en SHALL then follow REQ-014.
REQ-025 Reset asserted mid-word SHALL discard the partial and any stalled output word without emitting either.

Configuration
REQ-026 With macro FIFO_RD_PACKER_TIMEOUT_EN defined, a counter SHALL count cycles in ACCUM with no pop and SHALL trigger an internal flush on reaching TIMEOUT_CYCLES; any pop SHALL clear the count.
REQ-027 Without FIFO_RD_PACKER_TIMEOUT_EN, the timeout logic SHALL be absent, and partial words SHALL leave the block only via flush.

Structure
REQ-028 Package fifo_pkg SHALL hold BYTE_W=8, WORD_W=32, LANES=4 and the FSM state typedef (IDLE, ACCUM).
REQ-029 The timeout counter SHALL be a sub-module fifo_rd_packer_timer, instantiated only under FIFO_RD_PACKER_TIMEOUT_EN.

Verification
REQ-030 Bytes 0x11,0x22,0x33,0x44 on consecutive cycles with m_ready=1 -> m_data=0x44332211, m_keep=4'hF, m_valid for exactly 1 cycle.
REQ-031 8 bytes 0x01..0x08 with m_ready held 0 -> first word held stable, fifo_rd_en=0 with lane_cnt=3; on m_ready=1, words 0x04030201 then 0x08070605 back-to-back.
REQ-032 Bytes 0xAA,0xBB then flush=1 for one cycle -> m_data=0x0000BBAA, m_keep=4'b0011; flush in IDLE -> no output.
REQ-033 (TIMEOUT_EN, TIMEOUT_CYCLES=16) one byte 0x5A, FIFO then empty -> after 16 idle cycles m_data=0x0000005A, m_keep=4'b0001.
REQ-034 rst pulsed after 2 bytes, then 0xC1..0xC4 -> single word 0xC4C3C2C1 only; no stale bytes emitted.
